// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM stage: FSM encoding, alignment
// helpers and the EX/MEM control bundle carried across a memory access.
package mips_pkg;

    // FSM encoding. Plain constants keep the state vector a simple bit.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Low byte-address bits that must be zero for a word access.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Fields that travel with an instruction into the MEM/WB register.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  reg_write_reg;
        logic        reg_write;
        logic        mem_to_reg;
    } exmem_ctl_t;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return (byte_addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. ovalid and omem_err are single-cycle pulses
// that follow the load strobe; the data fields hold until the next load.
// An erroring instruction never writes the register file.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        err,
    input  exmem_ctl_t  ctl,
    input  logic [31:0] rdata,
    output logic        valid,
    output logic        mem_err,
    output logic [31:0] read_data,
    output logic [31:0] alu_result,
    output logic [4:0]  write_reg,
    output logic        reg_write,
    output logic        mem_to_reg
);

    // Capture a retiring instruction; valid/err pulse for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            mem_err    <= 1'b0;
            read_data  <= '0;
            alu_result <= '0;
            write_reg  <= '0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
        end else begin
            valid   <= load;
            mem_err <= load & err;
            if (load) begin
                read_data  <= rdata;
                alu_result <= ctl.alu_result;
                write_reg  <= ctl.reg_write_reg;
                reg_write  <= ctl.reg_write & ~err;
                mem_to_reg <= ctl.mem_to_reg;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: resolves branches, runs the data-memory req/ack access
// with a timeout, and feeds the MEM/WB register.
// Handshake: odmem_req rises on the edge that enters WAIT and, together with
// odmem_we/addr/wdata, stays stable until the cycle idmem_ack is sampled
// high; the access completes on that edge. ostall is high for every WAIT
// cycle, including the ack cycle, and upstream must hold while it is high.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DADDR_W = 10,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ivalid,
    input  logic               iSig_MemRead,
    input  logic               iSig_MemWrite,
    input  logic               iSig_Branch,
    input  logic               iSig_MemtoReg,
    input  logic               iSig_RegWrite,
    input  logic [31:0]        iadder_branch_result,
    input  logic               iALU_zero,
    input  logic [31:0]        iALU_result,
    input  logic [4:0]         ireg_write_reg,
    input  logic [31:0]        itemp_regfile_2,
    output logic               ostall,
    output logic               oPCSrc,
    output logic [31:0]        opc_branch_target,
    output logic               odmem_req,
    output logic               odmem_we,
    output logic [DADDR_W-1:0] odmem_addr,
    output logic [31:0]        odmem_wdata,
    input  logic               idmem_ack,
    input  logic [31:0]        idmem_rdata,
    output logic               ovalid,
    output logic [31:0]        oread_data,
    output logic [31:0]        oALU_result,
    output logic [4:0]         oreg_write_reg,
    output logic               oSig_RegWrite,
    output logic               oSig_MemtoReg,
    output logic               omem_err
);

    localparam int                CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    exmem_ctl_t       ex_q;
    exmem_ctl_t       in_ctl;

    logic        mem_op;
    logic        accept;
    logic        misalign;
    logic        start_access;
    logic        ack_done;
    logic        timed_out;
    logic        wb_load;
    logic        wb_err;
    exmem_ctl_t  wb_ctl;
    logic [31:0] wb_rdata;

    assign ostall = (state == ST_WAIT);

    // Decode the current cycle: what is accepted, finished or aborted.
    always_comb begin
        in_ctl.alu_result    = iALU_result;
        in_ctl.reg_write_reg = ireg_write_reg;
        in_ctl.reg_write     = iSig_RegWrite;
        in_ctl.mem_to_reg    = iSig_MemtoReg;

        mem_op       = iSig_MemRead | iSig_MemWrite;
        accept       = (state == ST_IDLE) & ivalid;
        misalign     = is_misaligned(iALU_result);
        start_access = accept & mem_op & ~misalign;
        ack_done     = (state == ST_WAIT) & idmem_ack;
        timed_out    = (state == ST_WAIT) & ~idmem_ack & (cnt == CNT_MAX);

        wb_load  = (accept & ~start_access) | ack_done | timed_out;
        wb_err   = 1'b0;
        wb_ctl   = in_ctl;
        wb_rdata = '0;
        if (state == ST_IDLE) begin
            wb_err = mem_op & misalign;
        end else begin
            wb_err = timed_out;
            wb_ctl = ex_q;
            if (ack_done && !odmem_we) begin
                wb_rdata = idmem_rdata;
            end
        end
    end

    // Access FSM and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_access) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (ack_done || timed_out) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Memory request port and the EX/MEM control latched for the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odmem_req   <= 1'b0;
            odmem_we    <= 1'b0;
            odmem_addr  <= '0;
            odmem_wdata <= '0;
            ex_q        <= '0;
        end else if (start_access) begin
            odmem_req   <= 1'b1;
            odmem_we    <= iSig_MemWrite;
            odmem_addr  <= iALU_result[DADDR_W+1:2];
            odmem_wdata <= itemp_regfile_2;
            ex_q        <= in_ctl;
        end else if (ack_done || timed_out) begin
            odmem_req <= 1'b0;
        end
    end

    // Branch resolution; a branch paired with a memory op is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oPCSrc            <= 1'b0;
            opc_branch_target <= '0;
        end else begin
            oPCSrc <= accept & ~mem_op & iSig_Branch & iALU_zero;
            if (accept && !mem_op) begin
                opc_branch_target <= iadder_branch_result;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wb_load),
        .err        (wb_err),
        .ctl        (wb_ctl),
        .rdata      (wb_rdata),
        .valid      (ovalid),
        .mem_err    (omem_err),
        .read_data  (oread_data),
        .alu_result (oALU_result),
        .write_reg  (oreg_write_reg),
        .reg_write  (oSig_RegWrite),
        .mem_to_reg (oSig_MemtoReg)
    );

endmodule
